// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: state encoding and mode constants for the scan decoder
package scan_decoder_pkg;
  typedef enum logic [1:0] {OFF, DIRECT, SCAN} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and decoded outputs of the scan decoder
interface scan_decoder_if #(parameter int SEL_W = 3, parameter int DIV_W = 16) ();
  localparam int OUT_W = 2 ** SEL_W;
  logic en;
  logic mode;
  logic [SEL_W-1:0] i;
  logic [DIV_W-1:0] div;
  logic [SEL_W-1:0] last;
  logic [OUT_W-1:0] d;
  logic [SEL_W-1:0] idx;
  logic frame;
  modport master (output en, mode, i, div, last, input d, idx, frame);
  modport slave (input en, mode, i, div, last, output d, idx, frame);
endinterface

// File: rtl/scan_decoder_tick_gen.sv
// tick_gen: free-running prescaler that ticks when the count reaches div
module tick_gen #(parameter int DIV_W = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = cnt == div;
  // count up, restarting from zero on clear or on reaching the period end
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: one-hot decoder with direct select and prescaled auto-scan
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
) (
  input logic clk,
  input logic rst,
  scan_decoder_if.slave bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [OUT_W-1:0] MSB = {1'b1, {(OUT_W-1){1'b0}}};
  state_t state, nxt;
  logic stay, tick, wrap, frame_n;
  logic [SEL_W-1:0] idx_n;
  logic [OUT_W-1:0] d_n;
  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (!stay),
    .div (bus.div),
    .tick(tick)
  );
  // next state and next output values; scan only steps while staying in SCAN
  always_comb begin
    nxt = !bus.en ? OFF : (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
    stay = (state == SCAN) && (nxt == SCAN);
    wrap = bus.idx >= bus.last;
    idx_n = (nxt == DIRECT) ? bus.i :
            (stay && tick) ? (wrap ? '0 : bus.idx + SEL_W'(1)) :
            stay ? bus.idx : '0;
    frame_n = stay && tick && wrap;
    d_n = (nxt == OFF) ? '0 : MSB >> idx_n;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      bus.d <= '0;
      bus.idx <= '0;
      bus.frame <= 1'b0;
    end else begin
      state <= nxt;
      bus.d <= d_n;
      bus.idx <= idx_n;
      bus.frame <= frame_n;
    end
  end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select/index width.
REQ-002 SHALL have parameter DIV_W, default 16: prescaler width.
REQ-003 SHALL derive OUT_W = 2**SEL_W internally; OUT_W is not overridable.
REQ-004 clk  in  1  rising-edge clock; one clock for the whole block.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 en  in  1  enable; 0 forces all outputs to zero.
REQ-007 mode  in  1  0 = direct decode of i, 1 = auto-scan.
REQ-008 i  in  SEL_W  select input, used in direct mode.
REQ-009 div  in  DIV_W  scan step period, in cycles, minus one.
REQ-010 last  in  SEL_W  highest index visited in scan mode.
REQ-011 d  out  OUT_W  registered one-hot output; index k drives bit OUT_W-1-k.
REQ-012 idx  out  SEL_W  registered index currently decoded onto d.
REQ-013 frame  out  1  one-cycle pulse when the scan wraps to index 0.

Function
REQ-014 SHALL implement states OFF, DIRECT and SCAN; the next state is evaluated every cycle: en=0 -> OFF; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
REQ-015 SHALL register all outputs; the response to en/mode/i appears one cycle after the sampling edge.
REQ-016 SHALL set d = 0, idx = 0, frame = 0 and clear the prescaler in OFF.
REQ-017 SHALL load idx <= i and d <= onehot(i) in DIRECT (bit OUT_W-1-i set), with the prescaler held at 0 and frame = 0.
REQ-018 On the edge entering SCAN from OFF or DIRECT, SHALL set idx = 0, d = MSB only, prescaler = 0 and frame = 0.
REQ-019 While remaining in SCAN, SHALL increment the prescaler each cycle; when prescaler == div, it SHALL clear to 0 and idx SHALL advance.
REQ-020 Advance rule: if idx >= last, idx <= 0 and frame <= 1 for that one cycle; otherwise idx <= idx+1.
REQ-021 d SHALL equal onehot(idx) in every cycle where the state is not OFF.
REQ-022 div = 0 SHALL advance idx every cycle; div = all-ones SHALL advance once every 2**DIV_W cycles.
REQ-023 last = 0 SHALL hold idx at 0 and pulse frame on every step.
REQ-024 If last is lowered below the current idx, SHALL wrap to 0 on the next step and pulse frame.
REQ-025 Changes to div mid-period SHALL take effect on the next comparison, with no prescaler reset.
REQ-026 i SHALL be ignored in SCAN; div and last SHALL be ignored outside SCAN.

Reset
REQ-027 rst = 1 at a clock edge SHALL force state OFF, d = 0, idx = 0, frame = 0 and prescaler = 0, overriding en and mode.
REQ-028 After rst is released, the first enabled cycle SHALL behave as entry from OFF, including the scan restart defined in REQ-018.

Structure
REQ-029 Package scan_decoder_pkg SHALL hold the state encoding constants (OFF, DIRECT, SCAN) and the mode constants (MODE_DIRECT = 0, MODE_SCAN = 1).
REQ-030 The prescaler SHALL be a sub-module tick_gen (ports: clk, rst, clr, div, tick).
REQ-031 The one-hot map SHALL be a reversed shift of a single 1, parametrised by SEL_W; no per-width case tables.

Verification (SEL_W=3)
REQ-032 Reset: rst=1 with en=1, mode=1 -> d=8'h00, idx=0, frame=0 on the next edge and held while rst=1.
REQ-033 Direct: en=1, mode=0, i=0 then i=7 then i=3 -> d=8'h80, 8'h01, 8'h10, each one cycle after i.
REQ-034 Scan: div=2, last=7 -> d=8'h80 for 3 cycles, then 8'h40 ... 8'h01 each for 3 cycles, then 8'h80 with frame=1 for exactly one cycle.
REQ-035 Short scan: div=0, last=2 -> d sequence 80,40,20,80,...; frame high on every third cycle, coincident with d=8'h80 after the wrap.
REQ-036 Mid-scan disable: en dropped at idx=5 -> d=0 and idx=0 next cycle; en re-raised -> d=8'h80 and scan restarts with a full period.
REQ-037 Mode switch: SCAN at idx=4 switched to mode=0 with i=6 -> d=8'h02 next cycle; switch back to SCAN -> d=8'h80, idx=0.
